// File: rtl/axi_lat_slave_mem.sv
// axi_lat_slave_mem: single-beat AXI slave memory model with programmable
// read/write latency, in-order R and B responses, SLVERR on out-of-range
// addresses or AW/W ID mismatch, and write-first bypass on same-cycle AR.

// Plain FIFO with a combinational head; used for the AW and W queues.
module axi_lat_slave_mem_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         not_empty,
    output logic [W-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  dat_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    assign full      = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);
    assign head      = dat_q[rd_ptr_q];

    // Payload storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) dat_q[wr_ptr_q] <= push_data;
    end

    // Pointers wrap modulo DEPTH; count carries one extra bit for full/empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end
endmodule

// Latency queue: each entry carries a countdown loaded with LAT on push.
// The head stays resident (and counted) while it is presented on the
// registered output, and leaves only on the valid/ready handshake.
module axi_lat_slave_mem_lat_q #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = $clog2(LAT + 1);

    logic [W-1:0]  dat_q [DEPTH];
    logic [LW-1:0] cnt_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q, nxt_ptr, cand_ptr;
    logic [CW-1:0] count_q;
    logic          pop, cand_avail, load;

    assign full = (count_q == CW'(DEPTH));
    assign pop  = out_valid && out_ready;

    // Pick the entry that may drive the output after this edge: the head when
    // idle, the one behind it when the head is leaving. A countdown of 1 now
    // reaches 0 at this edge, so the output register goes valid exactly LAT
    // edges after the push.
    always_comb begin
        nxt_ptr    = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        cand_ptr   = pop ? nxt_ptr : rd_ptr_q;
        cand_avail = pop ? (count_q >= CW'(2)) : (count_q >= CW'(1));
        load       = (!out_valid || pop) && cand_avail && (cnt_q[cand_ptr] <= LW'(1));
    end

    // Payload storage, not reset.
    always_ff @(posedge clk) begin
        if (push) dat_q[wr_ptr_q] <= push_data;
    end

    // Countdowns, pointers, count and the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                cnt_q[i] <= (cnt_q[i] == '0) ? '0 : cnt_q[i] - LW'(1);
            if (push) begin
                cnt_q[wr_ptr_q] <= LW'(LAT);
                wr_ptr_q        <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= nxt_ptr;
            count_q <= count_q + CW'(push) - CW'(pop);
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= dat_q[cand_ptr];
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

module axi_lat_slave_mem #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 576,
    parameter int ID_W     = 16,
    parameter int OFFSET_W = 6,
    parameter int MEM_AW   = 10,
    parameter int RD_LAT   = 4,
    parameter int WR_LAT   = 2,
    parameter int RQ_DEPTH = 4,
    parameter int WQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   arid_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [ID_W-1:0]   rid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    input  logic [ID_W-1:0]   awid_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [ID_W-1:0]   wid_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [ID_W-1:0]   bid_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i
);
    localparam int HI_LSB = OFFSET_W + MEM_AW;
    localparam int AWP    = ID_W + 1 + MEM_AW;  // {id, out_of_range, index}
    localparam int WP     = ID_W + DATA_W;      // {id, data}
    localparam int RP     = ID_W + 2 + DATA_W;  // {id, resp, data}
    localparam int BP     = ID_W + 2;           // {id, resp}

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word storage. Not reset; starts from the simulator's zero initial state.
    logic [DATA_W-1:0] mem [2**MEM_AW];

    logic [MEM_AW-1:0] ar_idx, aw_idx;
    logic              ar_oor, aw_oor;
    logic              ar_hs, aw_hs, w_hs;
    logic              r_full, aw_full, w_full, b_full;
    logic              aw_ne, w_ne;
    logic [AWP-1:0]    aw_head;
    logic [WP-1:0]     w_head;
    logic [RP-1:0]     r_out;
    logic [BP-1:0]     b_out;
    logic [ID_W-1:0]   aw_h_id, w_h_id;
    logic              aw_h_oor;
    logic [MEM_AW-1:0] aw_h_idx;
    logic [DATA_W-1:0] w_h_data, rd_data;
    logic              commit, wr_ok, wr_en;
    logic [1:0]        b_resp, r_resp;
    logic              unused_ok;

    // Byte-offset bits carry no information for a word-granular memory.
    assign unused_ok = &{1'b0, araddr_i[OFFSET_W-1:0], awaddr_i[OFFSET_W-1:0]};

    assign ar_idx = araddr_i[OFFSET_W +: MEM_AW];
    assign aw_idx = awaddr_i[OFFSET_W +: MEM_AW];
    assign ar_oor = |araddr_i[ADDR_W-1:HI_LSB];
    assign aw_oor = |awaddr_i[ADDR_W-1:HI_LSB];

    assign arready_o = !r_full;
    assign awready_o = !aw_full;
    assign wready_o  = !w_full;
    assign ar_hs     = arvalid_i && arready_o;
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;

    assign aw_h_id  = aw_head[AWP-1 -: ID_W];
    assign aw_h_oor = aw_head[MEM_AW];
    assign aw_h_idx = aw_head[MEM_AW-1:0];
    assign w_h_id   = w_head[WP-1 -: ID_W];
    assign w_h_data = w_head[DATA_W-1:0];

    // One commit per cycle pairs the AW and W heads in arrival order; the
    // memory is written only for a matching ID and an in-range address.
    always_comb begin
        commit = aw_ne && w_ne && !b_full;
        wr_ok  = (aw_h_id == w_h_id) && !aw_h_oor;
        wr_en  = commit && wr_ok && !rst;
        b_resp = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end

    // Read capture: a commit to the same word in this cycle wins over the
    // stored value; out-of-range reads return zero data.
    always_comb begin
        rd_data = mem[ar_idx];
        r_resp  = RESP_OKAY;
        if (wr_en && (aw_h_idx == ar_idx)) rd_data = w_h_data;
        if (ar_oor) begin
            rd_data = '0;
            r_resp  = RESP_SLVERR;
        end
    end

    // Memory write on commit.
    always_ff @(posedge clk) begin
        if (wr_en) mem[aw_h_idx] <= w_h_data;
    end

    axi_lat_slave_mem_fifo #(.W(AWP), .DEPTH(WQ_DEPTH)) u_aw_q (
        .clk(clk), .rst(rst),
        .push(aw_hs), .push_data({awid_i, aw_oor, aw_idx}),
        .pop(commit), .full(aw_full), .not_empty(aw_ne), .head(aw_head)
    );

    axi_lat_slave_mem_fifo #(.W(WP), .DEPTH(WQ_DEPTH)) u_w_q (
        .clk(clk), .rst(rst),
        .push(w_hs), .push_data({wid_i, wdata_i}),
        .pop(commit), .full(w_full), .not_empty(w_ne), .head(w_head)
    );

    axi_lat_slave_mem_lat_q #(.W(RP), .DEPTH(RQ_DEPTH), .LAT(RD_LAT)) u_r_q (
        .clk(clk), .rst(rst),
        .push(ar_hs), .push_data({arid_i, r_resp, rd_data}), .full(r_full),
        .out_valid(rvalid_o), .out_data(r_out), .out_ready(rready_i)
    );

    axi_lat_slave_mem_lat_q #(.W(BP), .DEPTH(WQ_DEPTH), .LAT(WR_LAT)) u_b_q (
        .clk(clk), .rst(rst),
        .push(commit), .push_data({aw_h_id, b_resp}), .full(b_full),
        .out_valid(bvalid_o), .out_data(b_out), .out_ready(bready_i)
    );

    assign rid_o   = r_out[RP-1 -: ID_W];
    assign rresp_o = r_out[DATA_W +: 2];
    assign rdata_o = r_out[DATA_W-1:0];
    assign bid_o   = b_out[BP-1 -: ID_W];
    assign bresp_o = b_out[1:0];
endmodule

// File: tb/tb_axi_lat_slave_mem.sv
// Scoreboard bench for axi_lat_slave_mem: stimulus pushes expected R/B beats,
// a negedge monitor pops and compares on every handshake.
module tb_axi_lat_slave_mem;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 576;
    localparam int ID_W   = 16;

    logic              clk, rst;
    logic [ID_W-1:0]   arid_i, rid_o, awid_i, wid_i, bid_o;
    logic [ADDR_W-1:0] araddr_i, awaddr_i;
    logic [DATA_W-1:0] rdata_o, wdata_i;
    logic [1:0]        rresp_o, bresp_o;
    logic arvalid_i, arready_o, rvalid_o, rready_i;
    logic awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i;

    axi_lat_slave_mem dut (
        .clk(clk), .rst(rst),
        .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wid_i(wid_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [ID_W-1:0] id; logic [DATA_W-1:0] data; logic [1:0] resp; } r_exp_t;
    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;
    r_exp_t r_q[$];
    b_exp_t b_q[$];
    r_exp_t re;
    b_exp_t be;
    int n_pass, n_total;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_r(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d, input logic [1:0] rs);
        r_q.push_back('{id: id, data: d, resp: rs});
    endtask

    task automatic exp_b(input logic [ID_W-1:0] id, input logic [1:0] rs);
        b_q.push_back('{id: id, resp: rs});
    endtask

    task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a);
        int n;
        arid_i = id; araddr_i = a; arvalid_i = 1'b1;
        n = 0;
        while (!arready_o && n < 50) begin tick(); n++; end
        if (!arready_o) check("ar_timeout", arready_o, 1);
        tick();
        arvalid_i = 1'b0;
    endtask

    task automatic send_aw_w(input logic [ID_W-1:0] aid, input logic [ID_W-1:0] wid,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        awid_i = aid; awaddr_i = a; awvalid_i = 1'b1;
        wid_i = wid; wdata_i = d; wvalid_i = 1'b1;
        n = 0;
        while (!(awready_o && wready_o) && n < 50) begin tick(); n++; end
        if (!(awready_o && wready_o)) check("aw_w_timeout", awready_o && wready_o, 1);
        tick();
        awvalid_i = 1'b0; wvalid_i = 1'b0;
    endtask

    // Ticks from the current point until the valid rises, bounded.
    task automatic wait_lat(input bit is_b, input int exp_n, input string name);
        int n;
        n = 0;
        while (!(is_b ? bvalid_o : rvalid_o) && n < 30) begin tick(); n++; end
        check(name, n, exp_n);
    endtask

    // Monitor: compare on handshakes, and check outputs hold under backpressure.
    logic              prev_rhold, prev_bhold;
    logic [ID_W-1:0]   prev_rid, prev_bid;
    logic [DATA_W-1:0] prev_rdata;
    logic [1:0]        prev_rresp, prev_bresp;
    always @(negedge clk) begin
        if (rst) begin
            prev_rhold = 1'b0;
            prev_bhold = 1'b0;
        end else begin
            if (prev_rhold) begin
                check("r_hold_valid", rvalid_o, 1);
                check("r_hold_id", rid_o, prev_rid);
                check("r_hold_data", rdata_o, prev_rdata);
                check("r_hold_resp", rresp_o, prev_rresp);
            end
            if (prev_bhold) begin
                check("b_hold_valid", bvalid_o, 1);
                check("b_hold_id", bid_o, prev_bid);
                check("b_hold_resp", bresp_o, prev_bresp);
            end
            if (rvalid_o && rready_i) begin
                if (r_q.size() == 0) check("r_unexpected", rvalid_o, 0);
                else begin
                    re = r_q.pop_front();
                    check("r_id", rid_o, re.id);
                    check("r_data", rdata_o, re.data);
                    check("r_resp", rresp_o, re.resp);
                end
            end
            if (bvalid_o && bready_i) begin
                if (b_q.size() == 0) check("b_unexpected", bvalid_o, 0);
                else begin
                    be = b_q.pop_front();
                    check("b_id", bid_o, be.id);
                    check("b_resp", bresp_o, be.resp);
                end
            end
            prev_rhold = rvalid_o && !rready_i;
            prev_bhold = bvalid_o && !bready_i;
            prev_rid = rid_o; prev_rdata = rdata_o; prev_rresp = rresp_o;
            prev_bid = bid_o; prev_bresp = bresp_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] t2_addr [5];
        bit acc, seen;
        int n;
        t2_addr = '{64'h40, 64'h0, 64'h40, 64'h80, 64'hC0};
        rst = 1'b1;
        arid_i = '0; araddr_i = '0; arvalid_i = 1'b0; rready_i = 1'b1;
        awid_i = '0; awaddr_i = '0; awvalid_i = 1'b0;
        wid_i = '0; wdata_i = '0; wvalid_i = 1'b0; bready_i = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_arready", arready_o, 1);
        check("rst_awready", awready_o, 1);
        check("rst_wready", wready_o, 1);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_bvalid", bvalid_o, 0);
        check("rst_rid", rid_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_rresp", rresp_o, 0);
        check("rst_bid", bid_o, 0);
        check("rst_bresp", bresp_o, 0);

        // Write then read: commit one edge after the push, B two edges later
        exp_b(3, 2'b00);
        send_aw_w(3, 3, 64'h40, 'hA5);
        wait_lat(1'b1, 3, "b_lat");
        repeat (2) tick();
        exp_r(9, 'hA5, 2'b00);
        send_ar(9, 64'h40);
        wait_lat(1'b0, 4, "r_lat");
        repeat (2) tick();

        // Read backpressure and full queue
        rready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            arid_i = ID_W'(10 + k); araddr_i = t2_addr[k]; arvalid_i = 1'b1;
            exp_r(ID_W'(10 + k), (t2_addr[k] == 64'h40) ? DATA_W'('hA5) : '0, 2'b00);
            tick();
        end
        check("ar_full", arready_o, 0);
        arid_i = 14; araddr_i = t2_addr[4];
        exp_r(14, '0, 2'b00);
        repeat (5) tick();
        check("ar_full_hold", arready_o, 0);
        check("r_bp_valid", rvalid_o, 1);
        check("r_bp_head", rid_o, 10);
        rready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("r_b2b", rvalid_o, 1);
            acc = arvalid_i && arready_o;
            tick();
            if (acc) arvalid_i = 1'b0;
        end
        repeat (10) tick();

        // Out-of-range read, ID-mismatch write under B backpressure
        exp_r(20, '0, 2'b10);
        send_ar(20, 64'h1_0000_0000);
        wait_lat(1'b0, 4, "oor_lat");
        repeat (2) tick();
        bready_i = 1'b0;
        exp_b(5, 2'b10);
        send_aw_w(5, 6, 64'h40, 'hFF);
        repeat (6) tick();
        check("b_bp_valid", bvalid_o, 1);
        check("b_bp_id", bid_o, 5);
        bready_i = 1'b1;
        repeat (2) tick();
        exp_r(21, 'hA5, 2'b00);
        send_ar(21, 64'h40);
        repeat (6) tick();

        // W three cycles ahead of AW
        wid_i = 7; wdata_i = 'h33; wvalid_i = 1'b1;
        tick();
        wvalid_i = 1'b0;
        repeat (2) tick();
        exp_b(7, 2'b00);
        awid_i = 7; awaddr_i = 64'h100; awvalid_i = 1'b1;
        tick();
        awvalid_i = 1'b0;
        wait_lat(1'b1, 3, "aw_late_b_lat");
        repeat (2) tick();
        exp_r(22, 'h33, 2'b00);
        send_ar(22, 64'h100);
        repeat (6) tick();

        // Same-cycle bypass: AR handshake on the commit edge to index 7
        exp_b(8, 2'b00);
        exp_r(30, 'h5A, 2'b00);
        awid_i = 8; awaddr_i = 64'h1C0; awvalid_i = 1'b1;
        wid_i = 8; wdata_i = 'h5A; wvalid_i = 1'b1;
        tick();
        awvalid_i = 1'b0; wvalid_i = 1'b0;
        arid_i = 30; araddr_i = 64'h1C0; arvalid_i = 1'b1;
        tick();
        arvalid_i = 1'b0;
        repeat (8) tick();
        exp_r(31, 'h5A, 2'b00);
        send_ar(31, 64'h1C0);
        repeat (6) tick();

        // Reset with two reads and one write pending
        arid_i = 40; araddr_i = 64'h0; arvalid_i = 1'b1;
        tick();
        arid_i = 41;
        awid_i = 42; awaddr_i = 64'h200; awvalid_i = 1'b1;
        wid_i = 42; wdata_i = 'h77; wvalid_i = 1'b1;
        tick();
        arvalid_i = 1'b0; awvalid_i = 1'b0; wvalid_i = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("mid_rst_arready", arready_o, 1);
        check("mid_rst_awready", awready_o, 1);
        check("mid_rst_wready", wready_o, 1);
        check("mid_rst_rvalid", rvalid_o, 0);
        check("mid_rst_bvalid", bvalid_o, 0);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (rvalid_o || bvalid_o) seen = 1'b1;
        end
        check("post_rst_quiet", seen, 0);
        exp_r(50, '0, 2'b00);
        send_ar(50, 64'h200);

        n = 0;
        while ((r_q.size() != 0 || b_q.size() != 0) && n < 50) begin tick(); n++; end
        check("r_q_drained", r_q.size(), 0);
        check("b_q_drained", b_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axi_lat_slave_mem.md
Name: axi_lat_slave_mem

Overview:
- Parametrised single-beat AXI slave memory model for the DRAM-cache benches. It stands in for the DRAM memory controller or the CXL endpoint.
- It adds per-channel outstanding queues, programmable read/write latency, an ordered B channel with response codes, an out-of-range error response, and a write-first read bypass.
- One instance is placed per downstream port, behind the cache controller's m_* or c_* channels.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 576, data width (tag sector 64 + line 512; set 512 for the CXL side).
- ID_W, 16, AXI ID width.
- OFFSET_W, 6, byte-offset bits dropped from the address.
- MEM_AW, 10, word-index bits; memory holds 2**MEM_AW words.
- RD_LAT, 4, cycles from AR handshake to earliest rvalid; must be ≥1.
- WR_LAT, 2, cycles from write commit to earliest bvalid; must be ≥1.
- RQ_DEPTH, 4, outstanding read entries; power of 2.
- WQ_DEPTH, 4, depth of each of the AW, W and B queues; power of 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- arid_i  in  ID_W  read ID.
- araddr_i  in  ADDR_W  read address.
- arvalid_i  in  1  AR valid.
- arready_o  out  1  AR ready.
- rid_o  out  ID_W  read response ID.
- rdata_o  out  DATA_W  read data.
- rresp_o  out  2  read response: 00 OKAY, 10 SLVERR.
- rvalid_o  out  1  R valid.
- rready_i  in  1  R ready.
- awid_i  in  ID_W  write ID.
- awaddr_i  in  ADDR_W  write address.
- awvalid_i  in  1  AW valid.
- awready_o  out  1  AW ready.
- wid_i  in  ID_W  write-data ID.
- wdata_i  in  DATA_W  write data.
- wvalid_i  in  1  W valid.
- wready_o  out  1  W ready.
- bid_o  out  ID_W  write response ID.
- bresp_o  out  2  write response: 00 OKAY, 10 SLVERR.
- bvalid_o  out  1  B valid.
- bready_i  in  1  B ready.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is rst: synchronous and active-high.
- Reset:
  - All queues are emptied and all counters cleared.
  - arready_o, awready_o and wready_o read 1 in the first cycle after reset; rvalid_o and bvalid_o read 0.
  - rid_o, rdata_o, rresp_o, bid_o and bresp_o read 0.
  - Memory contents are not reset; memory is zero-initialised at time 0.
  - Asserting rst mid-transaction discards all pending requests without issuing responses.
- Index and range check:
  - Word index is addr[OFFSET_W +: MEM_AW].
  - An address is out of range if any of addr[ADDR_W-1 : OFFSET_W+MEM_AW] is nonzero.
- Read path:
  - arready_o = read queue count < RQ_DEPTH; there is no same-cycle pop-through.
  - On AR handshake, the entry {id, data, resp, countdown=RD_LAT} is pushed. Data is sampled from memory in that cycle.
  - Write-first bypass: if a write commits to the same index in the same cycle, the new data is captured.
  - Out-of-range reads capture data 0 and resp SLVERR.
  - Every countdown decrements each cycle, saturating at 0.
  - The head drives R when its countdown reaches 0. rvalid_o is registered and asserts RD_LAT cycles after the handshake edge.
  - Responses are strictly in order. While rvalid_o=1 and rready_i=0, all R outputs hold stable.
  - Entries whose countdown has already expired issue back-to-back, one per cycle.
- Write path:
  - AW and W queues accept independently: awready_o = AW queue not full; wready_o = W queue not full.
  - Commit happens when both AW and W queues are non-empty and the B queue is not full. Both heads pop; pairing is in order.
  - Commit with wid == awid and in-range address: the memory word is written and resp is OKAY.
  - Commit with wid ≠ awid, or out-of-range address: no memory write, resp SLVERR.
  - On commit, {awid, resp, countdown=WR_LAT} is pushed to the B queue.
  - B uses the same valid/hold/in-order rules as R, with latency WR_LAT.
- Simultaneous events:
  - Push and pop on the same queue in one cycle leaves the count unchanged.
  - At most one commit per cycle.
  - AR and commit may occur in the same cycle.
- Pointers wrap modulo depth. The count width is log2(depth)+1, so full and empty are distinguished.

Test Plan:
- Write then read, RD_LAT=4, WR_LAT=2:
  - AW/W (id 3, addr 0x40, data 0xA5) → bvalid_o 2 cycles after commit, bid_o=3, bresp_o=00.
  - Then AR addr 0x40 → rvalid_o 4 cycles later, rdata_o=0xA5, rresp_o=00.
- Read backpressure and full queue:
  - With rready_i=0, issue 5 reads → arready_o=0 after 4 accepted.
  - R outputs hold stable.
  - Raise rready_i → 4 responses on consecutive cycles, IDs in issue order.
- Out of range / ID mismatch:
  - AR addr 0x1_0000_0000 → rresp_o=10, rdata_o=0.
  - AW id 5 with W id 6 → bresp_o=10; a subsequent read shows the memory unchanged.
- Decoupled AW/W:
  - W arrives 3 cycles before AW → commit occurs in the AW-pushed cycle+1.
  - bvalid_o follows WR_LAT later.
- Same-cycle bypass: AR to index 7 in the same cycle as a commit of 0x5A to index 7 → rdata_o=0x5A.
- Reset mid-operation:
  - Assert rst with 2 reads and 1 write pending → no responses after reset.
  - Ready outputs are 1, valid outputs are 0.
